// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the CPU front end.
//   XLEN       default datapath/address width
//   NOP_INSTR  canonical bubble instruction (addi x0, x0, 0)
//   if_state_t fetch-stage control states
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response channel.
//   imem_req   fetch request (held until imem_ready)
//   imem_addr  word-aligned fetch address
//   imem_ready response strobe; imem_rdata valid this cycle
//   imem_rdata fetched instruction
// master = fetch stage, slave = instruction memory.
interface if_stage_if #(
  parameter int XLEN = pipe_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched instruction that could not
// enter IF/ID because ID was stalled.
//   clk, rst   clock, asynchronous active-high reset (valid flag only)
//   load_i     capture {pc_i, instr_i}, entry becomes valid
//   drain_i    entry consumed, becomes empty
//   clear_i    discard entry (flush); wins over load/drain
//   valid_o, pc_o, instr_o  buffered entry
module if_skid_buf #(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is only meaningful while valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_i && !clear_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory
// handshake and produces the IF/ID pipeline register.
//   clk, rst        clock, asynchronous active-high reset
//   hazard          load-use stall from ID: hold IF/ID and PC
//   redirect_valid  taken branch/jump from EX (highest priority)
//   redirect_pc     redirect target, bits [1:0] ignored
//   imem            instruction-memory channel (master side)
//   if_id_valid/pc/instr  IF/ID register (instr = NOP when invalid)
//   stall_cycles    saturating count of hazard cycles without redirect
module if_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN     = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  if_stage_if.master        imem,
  output logic              if_id_valid,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       stall_cycles
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            ifv_q, ifv_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [31:0]     ifinstr_q, ifinstr_d;
  logic [31:0]     stall_q, stall_d;

  logic            buf_load, buf_drain, buf_clear;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_inc;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;
  assign pc_inc       = pc_q + PC_STEP;  // wraps modulo 2^XLEN

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .clear_i (buf_clear),
    .pc_i    (pc_q),
    .instr_i (imem.imem_rdata),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .instr_o (buf_instr)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifv_d     = ifv_q;
    ifpc_d    = ifpc_q;
    ifinstr_d = ifinstr_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_clear = 1'b0;

    if (redirect_valid) begin
      ifv_d     = 1'b0;
      ifinstr_d = NOP_INSTR;
      buf_clear = 1'b1;
      pc_d      = redirect_tgt;
      // A request still outstanding must be allowed to finish on the
      // wrong path; only a completed (or absent) request restarts at once.
      if ((state_q == REQ || state_q == KILL) && !imem.imem_ready) begin
        state_d = KILL;
      end else begin
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem.imem_ready) begin
            pc_d = pc_inc;
            if (!hazard) begin
              ifv_d     = 1'b1;
              ifpc_d    = pc_q;
              ifinstr_d = imem.imem_rdata;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end else if (!hazard) begin
            ifv_d     = 1'b0;
            ifinstr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!hazard) begin
            ifv_d     = buf_valid;
            ifpc_d    = buf_pc;
            ifinstr_d = buf_valid ? buf_instr : NOP_INSTR;
            buf_drain = 1'b1;
            state_d   = REQ;
          end
        end
        KILL: begin
          if (imem.imem_ready) begin
            state_d = REQ;
          end
          if (!hazard) begin
            ifv_d     = 1'b0;
            ifinstr_d = NOP_INSTR;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Latch the request address whenever a fresh request starts so that
    // it stays put through wait states and a KILL retarget of pc.
    addr_d = (state_d == REQ) ? pc_d : addr_q;

    stall_d = stall_q;
    if (hazard && !redirect_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      ifv_q     <= 1'b0;
      ifpc_q    <= '0;
      ifinstr_q <= NOP_INSTR;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ifv_q     <= ifv_d;
      ifpc_q    <= ifpc_d;
      ifinstr_q <= ifinstr_d;
      stall_q   <= stall_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ) || (state_q == KILL);
  assign imem.imem_addr = addr_q;
  assign if_id_valid    = ifv_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_instr    = ifinstr_q;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] stall_cycles;

  if_stage_if #(.XLEN(32)) imem ();

  if_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard         (hazard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model: the fetch stream described as "is a request out,
  // is it on the wrong path, what is waiting behind a stall".
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  bit          m_started, m_req_on, m_kill;
  logic [31:0] m_pc, m_addr, m_cnt;
  bit          m_v;
  logic [31:0] m_ifpc, m_ifinstr;
  entry_t      bufq[$];

  task automatic model_reset();
    m_started = 0; m_req_on = 0; m_kill = 0;
    m_pc = 32'h0; m_addr = 32'h0; m_cnt = 32'h0;
    m_v = 0; m_ifpc = 32'h0; m_ifinstr = NOP_INSTR;
    bufq.delete();
  endtask

  task automatic bubble();
    m_v = 0;
    m_ifinstr = NOP_INSTR;
  endtask

  task automatic model_step(input bit h, input bit r, input logic [31:0] rt,
                            input bit rdy, input logic [31:0] rd);
    entry_t e;
    if (h && !r && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (r) begin
      bubble();
      bufq.delete();
      m_pc = rt & ~32'h3;
      if (m_req_on && !rdy) m_kill = 1;
      else begin m_req_on = 1; m_kill = 0; m_addr = m_pc; end
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1; m_req_on = 1; m_addr = m_pc;
    end else if (m_req_on) begin
      if (rdy) begin
        if (m_kill) begin
          m_kill = 0; m_addr = m_pc;
          if (!h) bubble();
        end else if (!h) begin
          m_v = 1; m_ifpc = m_addr; m_ifinstr = rd;
          m_pc = m_pc + 4; m_addr = m_pc;
        end else begin
          e.pc = m_addr; e.instr = rd;
          bufq.push_back(e);
          m_pc = m_pc + 4; m_req_on = 0;
        end
      end else if (!h) bubble();
    end else if (!h) begin
      e = bufq.pop_front();
      m_v = 1; m_ifpc = e.pc; m_ifinstr = e.instr;
      m_req_on = 1; m_addr = m_pc;
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", imem.imem_req, m_req_on);
    if (m_req_on || !m_started) chk("imem_addr", imem.imem_addr, m_addr);
    chk("if_id_valid", if_id_valid, m_v);
    chk("if_id_instr", if_id_instr, m_v ? m_ifinstr : NOP_INSTR);
    if (m_v) chk("if_id_pc", if_id_pc, m_ifpc);
    chk("stall_cycles", stall_cycles, m_cnt);
  endtask

  // Called at a falling edge: check, drive, advance model, move to next falling edge.
  task automatic step(input bit h, input bit r, input logic [31:0] rt, input bit rdy);
    logic [31:0] rd;
    check_outputs();
    rd = memw(m_addr);
    hazard = h; redirect_valid = r; redirect_pc = rt;
    imem.imem_ready = rdy; imem.imem_rdata = rd;
    model_step(h, r, rt, rdy, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},   imem.imem_req, 1'b0);
    chk({tag, "_addr"},  imem.imem_addr, 32'h0);
    chk({tag, "_valid"}, if_id_valid, 1'b0);
    chk({tag, "_pc"},    if_id_pc, 32'h0);
    chk({tag, "_instr"}, if_id_instr, NOP_INSTR);
    chk({tag, "_stall"}, stall_cycles, 32'h0);
  endtask

  initial begin
    logic [31:0] cnt_before;
    bit h, r, rdy;
    logic [31:0] rt;

    rst = 1'b1; hazard = 0; redirect_valid = 0; redirect_pc = 0;
    imem.imem_ready = 0; imem.imem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Zero-wait stream from reset: first valid entry two edges after release.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("first_valid", if_id_valid, 1'b1);
    chk("first_pc", if_id_pc, 32'h0);
    chk("first_instr", if_id_instr, memw(32'h0));
    repeat (4) step(0, 0, 0, 1);

    // Three-cycle load-use stall with zero-wait memory.
    repeat (3) step(1, 0, 0, 1);
    chk("stall3", stall_cycles, 32'd3);
    repeat (4) step(0, 0, 0, 1);

    // Two memory wait states.
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1);

    // Redirect while a request is pending: KILL, then the target.
    step(0, 1, 32'h100, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("redir_pc", if_id_pc, 32'h100);
    step(0, 0, 0, 1);

    // Redirect together with hazard while an instruction is held.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    cnt_before = stall_cycles;
    step(1, 1, 32'h200, 1);
    chk("rh_nocount", stall_cycles, cnt_before);
    chk("rh_flush", if_id_valid, 1'b0);
    repeat (3) step(0, 0, 0, 1);

    // Address wrap; low target bits are ignored.
    step(0, 1, 32'hFFFF_FFFF, 1);
    chk("wrap_start", imem.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_addr", imem.imem_addr, 32'h0);
    repeat (2) step(0, 0, 0, 1);

    // Reset in the middle of KILL takes effect without a clock edge.
    step(0, 1, 32'h40, 0);
    step(0, 0, 0, 0);
    chk("kill_req", imem.imem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_values("midkill");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      h   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rt  = $urandom;
      if (m_kill && rdy) r = 0;
      step(h, r, rt, rdy);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
